// File: rtl/dca_matrix_lsu_row_scheduler_pkg.sv
// Shared definitions for the matrix LSU row scheduler and the row-buffer aligner.
// The txn-info word is packed as {last, first, alen, bitaddr}.
package dca_matrix_lsu_row_scheduler_pkg;

   localparam int ALEN_W     = 8;
   localparam int TXN_FLAG_W = 2;
   localparam int BITADDR_PAD = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Width of one packed txn-info word for a given byte address width.
   function automatic int txn_info_width(input int bw_addr);
      return TXN_FLAG_W + ALEN_W + bw_addr + BITADDR_PAD;
   endfunction

endpackage

// File: rtl/dca_matrix_lsu_burst_calc.sv
// Combinational AXI burst length for one matrix row starting at a byte address.
module dca_matrix_lsu_burst_calc
   import dca_matrix_lsu_row_scheduler_pkg::*;
#(
   parameter int BW_ADDR     = 32,
   parameter int BW_AXI_DATA = 32,
   parameter int BW_NUM_COL  = 8
) (
   input  logic [BW_ADDR-1:0]    addr,
   input  logic [BW_NUM_COL-1:0] num_col_m1,
   input  logic [2:0]            elem_lsa,
   output logic [ALEN_W-1:0]     alen
);

   localparam int BYTES = BW_AXI_DATA / 8;
   localparam int LG_B  = $clog2(BYTES);
   localparam int W     = BW_ADDR + BW_NUM_COL + 10;
   localparam logic [BW_ADDR-1:0] B_MASK = BW_ADDR'(BYTES - 1);
   localparam logic [W-1:0] ALEN_MAX = W'((1 << ALEN_W) - 1);

   logic [W-1:0] row_bits;
   logic [W-1:0] row_bytes;
   logic [W-1:0] byte_off;
   logic [W-1:0] beats;
   logic [W-1:0] beats_m1;

   // Everything is widened first so the saturation compare sees the true beat count.
   always_comb begin
      row_bits  = (W'(num_col_m1) + W'(1)) << elem_lsa;
      row_bytes = (row_bits + W'(7)) >> 3;
      byte_off  = W'(addr & B_MASK);
      beats     = (byte_off + row_bytes + W'(BYTES - 1)) >> LG_B;
      beats_m1  = beats - W'(1);
      alen      = (beats_m1 > ALEN_MAX) ? ALEN_MAX[ALEN_W-1:0] : beats_m1[ALEN_W-1:0];
   end

endmodule

// File: rtl/dca_matrix_lsu_row_scheduler.sv
// Splits one matrix load/store instruction into per-row AXI transactions,
// bounding rows in flight and signalling when every issued row has completed.
module dca_matrix_lsu_row_scheduler
   import dca_matrix_lsu_row_scheduler_pkg::*;
#(
   parameter int BW_ADDR         = 32,
   parameter int BW_AXI_DATA     = 32,
   parameter int BW_NUM_ROW      = 8,
   parameter int BW_NUM_COL      = 8,
   parameter int BW_STRIDE       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_valid,
   output logic                  inst_ready,
   input  logic [BW_ADDR-1:0]    inst_addr,
   input  logic [BW_STRIDE-1:0]  inst_stride,
   input  logic [BW_NUM_ROW-1:0] inst_num_row_m1,
   input  logic [BW_NUM_COL-1:0] inst_num_col_m1,
   input  logic [2:0]            inst_elem_lsa,
   output logic                  txn_valid,
   input  logic                  txn_ready,
   output logic [BW_ADDR+2:0]    txn_bitaddr,
   output logic [ALEN_W-1:0]     txn_alen,
   output logic                  txn_first,
   output logic                  txn_last,
   input  logic                  cpl_valid,
   output logic                  cpl_ready,
   output logic                  busy,
   output logic                  inst_done
);

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   logic [1:0]            state;
   logic [BW_NUM_ROW-1:0] row_cnt;
   logic [BW_NUM_ROW-1:0] row_cnt_inc;
   logic [BW_NUM_ROW-1:0] num_row_m1_q;
   logic [BW_NUM_COL-1:0] num_col_m1_q;
   logic [2:0]            elem_lsa_q;
   logic [BW_STRIDE-1:0]  stride_q;
   logic [BW_ADDR-1:0]    addr_cur;
   logic [BW_ADDR-1:0]    addr_next;
   logic [3:0]            outstanding;
   logic [3:0]            outstanding_next;
   logic                  issue_fire;
   logic                  cpl_take;

   logic [BW_ADDR-1:0]    calc_addr;
   logic [BW_NUM_COL-1:0] calc_col;
   logic [2:0]            calc_lsa;
   logic [ALEN_W-1:0]     calc_alen;

   assign inst_ready  = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign cpl_ready   = 1'b1;
   assign txn_valid   = (state == ST_ISSUE) && (outstanding < MAX_OUT);
   assign issue_fire  = txn_valid && txn_ready;
   assign cpl_take    = cpl_valid && (outstanding != 4'd0);
   assign addr_next   = addr_cur + BW_ADDR'(stride_q);
   assign row_cnt_inc = row_cnt + BW_NUM_ROW'(1);

   always_comb begin
      outstanding_next = outstanding;
      case ({issue_fire, cpl_take})
         2'b10:   outstanding_next = outstanding + 4'd1;
         2'b01:   outstanding_next = outstanding - 4'd1;
         default: outstanding_next = outstanding;
      endcase
   end

   // One calculator serves both the first row (from the request) and each following row.
   always_comb begin
      calc_addr = addr_next;
      calc_col  = num_col_m1_q;
      calc_lsa  = elem_lsa_q;
      if (state == ST_IDLE) begin
         calc_addr = inst_addr;
         calc_col  = inst_num_col_m1;
         calc_lsa  = inst_elem_lsa;
      end
   end

   dca_matrix_lsu_burst_calc #(
      .BW_ADDR     (BW_ADDR),
      .BW_AXI_DATA (BW_AXI_DATA),
      .BW_NUM_COL  (BW_NUM_COL)
   ) u_burst_calc (
      .addr       (calc_addr),
      .num_col_m1 (calc_col),
      .elem_lsa   (calc_lsa),
      .alen       (calc_alen)
   );

   // The txn fields always describe the row at addr_cur, so they stay put during stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         row_cnt      <= '0;
         num_row_m1_q <= '0;
         num_col_m1_q <= '0;
         elem_lsa_q   <= '0;
         stride_q     <= '0;
         addr_cur     <= '0;
         outstanding  <= '0;
         txn_bitaddr  <= '0;
         txn_alen     <= '0;
         txn_first    <= 1'b0;
         txn_last     <= 1'b0;
         inst_done    <= 1'b0;
      end else begin
         inst_done   <= 1'b0;
         outstanding <= outstanding_next;
         case (state)
            ST_IDLE: begin
               if (inst_valid) begin
                  num_row_m1_q <= inst_num_row_m1;
                  num_col_m1_q <= inst_num_col_m1;
                  elem_lsa_q   <= inst_elem_lsa;
                  stride_q     <= inst_stride;
                  addr_cur     <= inst_addr;
                  row_cnt      <= '0;
                  txn_bitaddr  <= {inst_addr, 3'b000};
                  txn_alen     <= calc_alen;
                  txn_first    <= 1'b1;
                  txn_last     <= (inst_num_row_m1 == '0);
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_fire) begin
                  addr_cur    <= addr_next;
                  row_cnt     <= row_cnt_inc;
                  txn_bitaddr <= {addr_next, 3'b000};
                  txn_alen    <= calc_alen;
                  txn_first   <= 1'b0;
                  txn_last    <= (row_cnt_inc == num_row_m1_q);
                  if (txn_last) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (outstanding_next == 4'd0) begin
                  state     <= ST_IDLE;
                  inst_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dca_matrix_lsu_row_scheduler.sv
// Self-checking bench: directed steps plus randomized instructions checked
// against an arithmetic row/burst model and an outstanding-row count.
module tb_dca_matrix_lsu_row_scheduler;

   localparam int MAXO  = 2;
   localparam int BYTES = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic [31:0] inst_addr = '0;
   logic [15:0] inst_stride = '0;
   logic [7:0]  inst_num_row_m1 = '0;
   logic [7:0]  inst_num_col_m1 = '0;
   logic [2:0]  inst_elem_lsa = '0;
   logic        txn_valid;
   logic        txn_ready = 1'b0;
   logic [34:0] txn_bitaddr;
   logic [7:0]  txn_alen;
   logic        txn_first;
   logic        txn_last;
   logic        cpl_valid = 1'b0;
   logic        cpl_ready;
   logic        busy;
   logic        inst_done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dca_matrix_lsu_row_scheduler #(
      .BW_ADDR         (32),
      .BW_AXI_DATA     (32),
      .BW_NUM_ROW      (8),
      .BW_NUM_COL      (8),
      .BW_STRIDE       (16),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_addr       (inst_addr),
      .inst_stride     (inst_stride),
      .inst_num_row_m1 (inst_num_row_m1),
      .inst_num_col_m1 (inst_num_col_m1),
      .inst_elem_lsa   (inst_elem_lsa),
      .txn_valid       (txn_valid),
      .txn_ready       (txn_ready),
      .txn_bitaddr     (txn_bitaddr),
      .txn_alen        (txn_alen),
      .txn_first       (txn_first),
      .txn_last        (txn_last),
      .cpl_valid       (cpl_valid),
      .cpl_ready       (cpl_ready),
      .busy            (busy),
      .inst_done       (inst_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Beats needed to cover byte_off + ceil(row_bits/8) bytes, minus one, capped at 255.
   function automatic int ref_alen(input logic [31:0] a, input int nc, input int lsa);
      int bits;
      int nbytes;
      int off;
      int beats;
      bits   = (nc + 1) * (1 << lsa);
      nbytes = (bits + 7) / 8;
      off    = int'(a % BYTES);
      beats  = (off + nbytes + BYTES - 1) / BYTES;
      return (beats - 1 > 255) ? 255 : beats - 1;
   endfunction

   task automatic start_inst(input logic [31:0] a, input logic [15:0] s,
                             input int nr, input int nc, input int lsa);
      inst_valid      = 1'b1;
      inst_addr       = a;
      inst_stride     = s;
      inst_num_row_m1 = 8'(nr);
      inst_num_col_m1 = 8'(nc);
      inst_elem_lsa   = 3'(lsa);
      step();
      inst_valid = 1'b0;
   endtask

   // Runs one instruction to completion with random ready/completion traffic.
   task automatic run_inst(input logic [31:0] a, input logic [15:0] s, input int nr,
                           input int nc, input int lsa, input int rdyp, input int cplp);
      logic [34:0] q_bit[$];
      int          q_alen[$];
      logic [31:0] ra;
      int          idx;
      int          mout;
      int          mout_new;
      bit          exp_valid;
      bit          hs;
      bit          drain;
      bit          done_exp;
      bit          finished;
      ra = a;
      for (int r = 0; r <= nr; r++) begin
         q_bit.push_back({ra, 3'b000});
         q_alen.push_back(ref_alen(ra, nc, lsa));
         ra = ra + 32'(s);
      end
      check("ready_before_inst", inst_ready, 1);
      start_inst(a, s, nr, nc, lsa);
      check("busy_after_accept", busy, 1);
      idx = 0;
      mout = 0;
      done_exp = 0;
      finished = 0;
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         check("inst_done", inst_done, done_exp);
         if (done_exp) begin
            check("ready_after_done", inst_ready, 1);
            check("busy_after_done", busy, 0);
            check("valid_after_done", txn_valid, 0);
            finished = 1;
         end else begin
            check("ready_while_busy", inst_ready, 0);
            exp_valid = (idx <= nr) && (mout < MAXO);
            check("txn_valid", txn_valid, exp_valid);
            if (exp_valid) begin
               check("txn_bitaddr", txn_bitaddr, q_bit[idx]);
               check("txn_alen", txn_alen, q_alen[idx]);
               check("txn_first", txn_first, idx == 0);
               check("txn_last", txn_last, idx == nr);
            end
            txn_ready  = ($urandom % 100) < rdyp;
            cpl_valid  = ($urandom % 100) < cplp;
            inst_valid = ($urandom % 4) == 0;
            inst_addr  = $urandom;
            hs    = exp_valid && txn_ready;
            drain = idx > nr;
            mout_new = mout + (hs ? 1 : 0) - ((cpl_valid && mout > 0) ? 1 : 0);
            if (hs) idx++;
            done_exp = drain && (mout_new == 0);
            if (done_exp) inst_valid = 1'b0;
            mout = mout_new;
            step();
         end
      end
      check("inst_finished_in_budget", finished, 1);
      txn_ready  = 1'b0;
      cpl_valid  = 1'b0;
      inst_valid = 1'b0;
   endtask

   initial begin
      // Reset values
      step();
      step();
      check("rst_inst_ready", inst_ready, 1);
      check("rst_txn_valid", txn_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_inst_done", inst_done, 0);
      check("rst_bitaddr", txn_bitaddr, 0);
      check("rst_alen", txn_alen, 0);
      check("rst_first_last", {txn_first, txn_last}, 0);
      check("cpl_ready", cpl_ready, 1);
      rst = 1'b0;
      step();

      // Basic three-row instruction: bitaddrs 0x800/0xA00/0xC00, alen 1
      run_inst(32'h100, 16'h40, 2, 7, 3, 100, 100);
      // Misaligned vs aligned, sub-byte elements, single rows
      run_inst(32'h103, 16'h40, 0, 3, 3, 100, 100);
      run_inst(32'h100, 16'h40, 0, 3, 3, 100, 100);
      run_inst(32'h100, 16'h08, 1, 15, 0, 100, 100);
      // Burst saturation and address wrap
      run_inst(32'h1, 16'h400, 1, 255, 5, 100, 80);
      run_inst(32'h0, 16'h3FC, 0, 254, 5, 100, 80);
      run_inst(32'hFFFF_FFF8, 16'hFFFF, 2, 5, 2, 70, 60);

      // Outstanding limit of 2 with completions held off
      txn_ready = 1'b1;
      cpl_valid = 1'b0;
      start_inst(32'h200, 16'h10, 3, 3, 3);
      check("lim_row0_valid", txn_valid, 1);
      check("lim_row0_first", txn_first, 1);
      check("lim_row0_bitaddr", txn_bitaddr, 35'h1000);
      step();
      check("lim_row1_valid", txn_valid, 1);
      step();
      check("lim_blocked", txn_valid, 0);
      step();
      check("lim_still_blocked", txn_valid, 0);
      check("lim_busy", busy, 1);
      cpl_valid = 1'b1;
      step();
      cpl_valid = 1'b0;
      check("lim_row2_valid", txn_valid, 1);
      check("lim_row2_bitaddr", txn_bitaddr, 35'h1100);
      txn_ready = 1'b0;
      step();
      check("stall_valid", txn_valid, 1);
      check("stall_bitaddr", txn_bitaddr, 35'h1100);
      check("stall_alen", txn_alen, ref_alen(32'h220, 3, 3));
      check("stall_flags", {txn_first, txn_last}, 2'b00);
      step();
      check("stall2_bitaddr", txn_bitaddr, 35'h1100);
      txn_ready = 1'b1;
      step();
      check("lim_after_row2", txn_valid, 0);
      cpl_valid = 1'b1;
      step();
      check("lim_row3_valid", txn_valid, 1);
      check("lim_row3_last", txn_last, 1);
      step();
      check("simul_drain_valid", txn_valid, 0);
      check("simul_drain_busy", busy, 1);
      check("simul_no_done", inst_done, 0);
      step();
      check("lim_done", inst_done, 1);
      check("lim_ready", inst_ready, 1);
      step();
      cpl_valid = 1'b0;
      check("spurious_no_done", inst_done, 0);
      check("spurious_idle", busy, 0);

      // Reset in the middle of an instruction after row 1 has issued
      start_inst(32'h300, 16'h20, 3, 7, 3);
      check("pre_rst_row0_valid", txn_valid, 1);
      step();
      check("pre_rst_row1_valid", txn_valid, 1);
      step();
      check("pre_rst_blocked", txn_valid, 0);
      rst = 1'b1;
      #1;
      check("midrst_valid", txn_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", inst_ready, 1);
      check("midrst_bitaddr", txn_bitaddr, 0);
      check("midrst_alen", txn_alen, 0);
      check("midrst_flags", {txn_first, txn_last}, 0);
      check("midrst_done", inst_done, 0);
      txn_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("post_rst_no_done", inst_done, 0);
      run_inst(32'h400, 16'h20, 3, 7, 3, 100, 70);

      // Randomized instructions
      for (int n = 0; n < 12; n++) begin
         run_inst($urandom, 16'($urandom), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 5)),
                  int'($urandom_range(40, 100)), int'($urandom_range(30, 90)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dca_matrix_lsu_row_scheduler.md
Name: dca_matrix_lsu_row_scheduler

Overview:
- Sequences one matrix load/store instruction into per-row memory transactions for the matrix LSU row-buffer aligner.
- Walks rows from a base address by a byte stride and computes each row's bit address and AXI burst length.
- Emits one txn-info word per row, limits outstanding rows, and reports instruction completion once every issued row has completed.

Parameters:
- BW_ADDR, 32, byte address width
- BW_AXI_DATA, 32, AXI data width in bits (power of 2, 8..1024)
- BW_NUM_ROW, 8, width of num_row_m1
- BW_NUM_COL, 8, width of num_col_m1
- BW_STRIDE, 16, byte stride width (unsigned)
- MAX_OUTSTANDING, 4, maximum issued-but-uncompleted rows (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- inst_valid  in  1  instruction request
- inst_ready  out  1  instruction accepted (high in IDLE)
- inst_addr  in  BW_ADDR  matrix base byte address
- inst_stride  in  BW_STRIDE  row stride in bytes
- inst_num_row_m1  in  BW_NUM_ROW  rows minus 1
- inst_num_col_m1  in  BW_NUM_COL  columns minus 1
- inst_elem_lsa  in  3  log2 element bits (0..5 means 1..32 bits)
- txn_valid  out  1  row transaction valid
- txn_ready  in  1  downstream accepts
- txn_bitaddr  out  BW_ADDR+3  row bit address: byte address concatenated with 3'b000
- txn_alen  out  8  AXI ALEN (beats minus 1)
- txn_first  out  1  first row of instruction
- txn_last  out  1  last row of instruction
- cpl_valid  in  1  one row's data phase completed
- cpl_ready  out  1  tied 1
- busy  out  1  state is not IDLE
- inst_done  out  1  one-cycle pulse when the instruction finishes

Behaviour:
- Reset values:
  - state IDLE; row_cnt, outstanding and addr_cur all 0.
  - Outputs: txn_valid, txn_first, txn_last, txn_bitaddr, txn_alen, busy and inst_done are 0; inst_ready is 1.
- Row length in bits: row_bits = (num_col_m1+1) << elem_lsa. row_bytes = ceil(row_bits/8).
- Burst length:
  - B = BW_AXI_DATA/8.
  - byte_off = addr_cur mod B.
  - txn_alen = ceil((byte_off + row_bytes)/B) - 1, saturated at 255.
- IDLE:
  - inst_ready=1.
  - On inst_valid, latch all instruction fields, set addr_cur=inst_addr and row_cnt=0, go to ISSUE.
- ISSUE:
  - txn_valid=1 iff outstanding < MAX_OUTSTANDING.
  - txn fields are registered and held stable while txn_valid && !txn_ready.
  - txn_first = (row_cnt==0); txn_last = (row_cnt==num_row_m1).
  - On handshake: addr_cur += stride (mod 2^BW_ADDR, wraps); row_cnt++; outstanding++.
  - On handshake with txn_last, go to DRAIN.
- Completion: cpl_valid decrements outstanding.
  - A simultaneous issue and completion leaves outstanding unchanged.
  - cpl_valid while outstanding==0 is ignored; the counter does not underflow.
- DRAIN:
  - When outstanding reaches 0 (including by this cycle's decrement), the next cycle is IDLE and inst_done pulses high for exactly that one cycle.
- Latency:
  - First txn_valid appears 1 cycle after inst acceptance.
  - Back-to-back rows issue one per cycle while txn_ready=1 and outstanding < MAX_OUTSTANDING.
- Single row (num_row_m1=0): the only txn has both txn_first and txn_last set.
- rst mid-operation: immediate return to reset values. Pending rows are dropped; no inst_done.
- inst_valid outside IDLE is not accepted (inst_ready=0).

Decomposition:
- Shared package/header holds:
  - txn-info field widths and the packing order {last, first, alen, bitaddr}, shared with the aligner's BW_TXN_INFO;
  - the state encodings IDLE=0, ISSUE=1, DRAIN=2;
  - ALEN width 8.
- One natural sub-module: dca_matrix_lsu_burst_calc, combinational (addr, num_col_m1, elem_lsa) to alen.
- The outstanding counter stays inline.

Test Plan:
- Basic:
  - Stimulus: BW_AXI_DATA=32, addr=0x100, stride=0x40, num_row_m1=2, num_col_m1=7, elem_lsa=3; txn_ready=1, cpl_valid one cycle after each txn.
  - Response: txn bitaddrs 0x800, 0xA00, 0xC00; alen=1 each; first on row 0 and last on row 2; inst_done pulses once.
- Misaligned address:
  - Stimulus: addr=0x103, num_col_m1=3, elem_lsa=3.
  - Response: byte_off=3, row_bytes=4, alen=1.
  - Stimulus: addr=0x100.
  - Response: alen=0.
- Sub-byte elements:
  - Stimulus: num_col_m1=15, elem_lsa=0.
  - Response: row_bytes=2, alen=0, txn_bitaddr low 3 bits 0.
- Backpressure and outstanding limit:
  - Stimulus: MAX_OUTSTANDING=2, 4 rows, cpl_valid held low.
  - Response: exactly 2 txns issue, then txn_valid=0.
  - Stimulus: one cpl_valid pulse.
  - Response: third row issues next cycle; fields stable during txn_ready=0 stalls.
- Simultaneous and spurious completion:
  - Stimulus: issue and cpl_valid in the same cycle.
  - Response: outstanding unchanged.
  - Stimulus: cpl_valid in IDLE.
  - Response: counter stays 0; no inst_done.
- Reset mid-operation:
  - Stimulus: assert rst during ISSUE after row 1.
  - Response: all outputs return to reset values immediately and inst_ready=1. A new instruction restarts with txn_first=1.
